// File: rtl/nanov_fetch_sequencer.sv
// SPI flash instruction fetch and cycle/counter sequencer feeding the nanoV core.
// Optional feature macro: NANOV_FETCH_FAST_READ_EN (0x0B fast read, 8 dummy clocks).
module nanov_fetch_sequencer #(
  parameter int          ADDR_BITS = 24,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_miso,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        spi_clk_en,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic        run,
  output logic [4:0]  counter,
  output logic [2:0]  cycle,
  output logic [31:0] instr,
  output logic [30:0] next_instr,
  output logic        pc
);

`ifdef NANOV_FETCH_FAST_READ_EN
  localparam int          CMD_LEN  = 40;
  localparam logic [7:0]  READ_CMD = 8'h0B;
`else
  localparam int          CMD_LEN  = 32;
  localparam logic [7:0]  READ_CMD = 8'h03;
`endif

  typedef enum logic [1:0] {S_GAP, S_CMD, S_FILL, S_RUN} state_t;

  state_t               state, state_nxt;
  logic [5:0]           seq_cnt;
  logic [CMD_LEN-1:0]   cmd_sr, cmd_load;
  logic [23:0]          addr24;
  logic [31:0]          pbuf, pbuf_nxt, pc_reg;
  logic                 pending;
  logic [1:0]           last_cyc;
  logic [4:0]           bit_idx, dst_idx;
  logic                 sample, instr_end, redirect;
  logic                 cs_n_nxt, clk_en_nxt, run_nxt;
  logic [4:0]           counter_nxt;
  logic [2:0]           cycle_nxt;
  logic                 unused_bt0;

  assign unused_bt0 = branch_target[0];
  assign spi_mosi   = cmd_sr[CMD_LEN-1];
  assign pc         = pc_reg[counter];

  // Command word: opcode, 24-bit zero-padded address, then dummy zeros for fast read.
  always_comb begin
    addr24 = '0;
    addr24[ADDR_BITS-1:0] = pc_reg[ADDR_BITS-1:0];
    cmd_load = '0;
    cmd_load[CMD_LEN-1 -: 32] = {READ_CMD, addr24};
  end

  always_comb begin
    last_cyc = 2'd0;
    if (instr[6:2] == 5'b00000)
      last_cyc = 2'd2;
    else if ((instr[6:4] == 3'b110 && instr[2]) || instr[6:2] == 5'b11000 ||
             instr[6:2] == 5'b01000 || (instr[4:2] == 3'b100 && instr[13:12] == 2'b01))
      last_cyc = 2'd1;
  end

  // Bytes arrive byte0 first, each MSB-first: stream bit i lands at 8*(i/8) + 7-(i%8).
  always_comb begin
    sample   = spi_clk_en && (state == S_FILL || state == S_RUN);
    bit_idx  = (state == S_FILL) ? seq_cnt[4:0] : counter;
    dst_idx  = {bit_idx[4:3], ~bit_idx[2:0]};
    pbuf_nxt = pbuf;
    if (sample) pbuf_nxt[dst_idx] = spi_miso;
  end

  always_comb begin
    next_instr = pbuf[30:0];
    if (state == S_RUN && cycle == 3'd0 && counter == 5'd31) next_instr[24] = spi_miso;
  end

  assign instr_end = (state == S_RUN) && (counter == 5'd31) && (cycle == {1'b0, last_cyc});
  assign redirect  = instr_end && (pending || branch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_GAP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_GAP:   state_nxt = S_CMD;
      S_CMD:   if (seq_cnt == 6'(CMD_LEN-1)) state_nxt = S_FILL;
      S_FILL:  if (seq_cnt == 6'd31) state_nxt = S_RUN;
      S_RUN:   if (redirect) state_nxt = S_GAP;
      default: state_nxt = S_GAP;
    endcase
    counter_nxt = '0;
    cycle_nxt   = '0;
    if (state == S_RUN && state_nxt == S_RUN) begin
      counter_nxt = counter + 5'd1;
      if (instr_end)              cycle_nxt = '0;
      else if (counter == 5'd31)  cycle_nxt = cycle + 3'd1;
      else                        cycle_nxt = cycle;
    end
    cs_n_nxt   = (state_nxt == S_GAP);
    run_nxt    = (state_nxt == S_RUN);
    clk_en_nxt = (state_nxt == S_CMD) || (state_nxt == S_FILL) ||
                 (state_nxt == S_RUN && cycle_nxt == 3'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_cs_n   <= 1'b1;
      spi_clk_en <= 1'b0;
      run        <= 1'b0;
      counter    <= '0;
      cycle      <= '0;
      seq_cnt    <= '0;
      cmd_sr     <= '0;
      pbuf       <= '0;
      instr      <= 32'h0000_0013;
      pc_reg     <= RESET_PC;
      pending    <= 1'b0;
    end else begin
      spi_cs_n   <= cs_n_nxt;
      spi_clk_en <= clk_en_nxt;
      run        <= run_nxt;
      counter    <= counter_nxt;
      cycle      <= cycle_nxt;
      pbuf       <= pbuf_nxt;
      seq_cnt    <= (state_nxt == state && (state == S_CMD || state == S_FILL)) ? seq_cnt + 6'd1 : '0;
      if (state == S_GAP)      cmd_sr <= cmd_load;
      else if (state == S_CMD) cmd_sr <= {cmd_sr[CMD_LEN-2:0], 1'b0};
      if (state == S_FILL && state_nxt == S_RUN) begin
        instr <= pbuf_nxt;
      end else if (instr_end && !redirect) begin
        instr  <= pbuf_nxt;
        pc_reg <= pc_reg + 32'd4;
      end
      // Redirect discards the sequential prefetch; instr holds until the refill completes.
      if (redirect) begin
        pc_reg  <= {branch_target[31:1], 1'b0};
        pending <= 1'b0;
      end else if (state == S_RUN && branch) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/nanov_fetch_sequencer.md
# nanov_fetch_sequencer

Instruction-fetch and sequencing stage sitting directly upstream of the nanoV core. It drives a single-bit SPI flash read stream and assembles little-endian instruction words. It generates the `counter`/`cycle` timebase, presents `instr`/`next_instr` and a bit-serial `pc`, and redirects the fetch stream when the core signals a taken branch or jump.

## Interface
Parameters:
- `ADDR_BITS`, 24: flash address width; the command sends `pc[ADDR_BITS-1:0]` MSB-first (zero-padded to 24 bits).
- `RESET_PC`, 32'h0000_0000: PC value after reset.

Ports:
- `clk` in 1: system clock; the SPI clock is `clk` gated by `spi_clk_en`.
- `rst` in 1: reset, asynchronous, active-high.
- `spi_miso` in 1: flash data, sampled on `clk` rising edge when `spi_clk_en`=1.
- `spi_mosi` out 1: command/address bit.
- `spi_cs_n` out 1: flash select, active-low.
- `spi_clk_en` out 1: flash clock enable (stall = 0).
- `branch` in 1: taken branch or jump from the core, any cycle of the current instruction.
- `branch_target` in 32: parallel target (core `data_out`), sampled at instruction end.
- `run` out 1: high while the core may execute (RUN state).
- `counter` out 5: bit index within a cycle, 0..31.
- `cycle` out 3: cycle index within an instruction.
- `instr` out 32: current instruction.
- `next_instr` out 31: prefetched instruction bits [30:0].
- `pc` out 1: `pc_reg[counter]`, i.e. the current instruction's PC bit-serially, LSB-first.

## Operation
- States: GAP → CMD → FILL → RUN; RUN → GAP on a redirect.
- GAP: 1 clock. `spi_cs_n`=1, `spi_clk_en`=0, `run`=0.
- CMD: `spi_cs_n`=0, `spi_clk_en`=1. Shifts 8'h03 then the 24-bit address on `spi_mosi`, MSB-first, for 32 clocks.
- FILL: 32 clocks receiving a word into the prefetch buffer.
  - Byte order: byte0 first. Each byte arrives MSB-first. Byte k fills `instr[8k+7:8k]`.
  - On the FILL→RUN transition: `instr` ← buffer, `counter`=0, `cycle`=0.
- RUN, cycle 0: `spi_clk_en`=1; the next sequential word streams into the prefetch buffer.
- RUN, cycles >0: `spi_clk_en`=0. The flash stalls with CS held low.
- Cycles per instruction, decoded from `instr`:
  - JAL/JALR (`[6:4]`=110, `[2]`=1), BRANCH (`[6:2]`=11000), STORE (`[6:2]`=01000), shifts (`[4:2]`=100, `[13:12]`=01): 2 cycles.
  - LOAD (`[6:2]`=00000): 3 cycles.
  - All other instructions: 1 cycle.
- `counter` increments every RUN clock. After 31 it wraps to 0 and `cycle` increments. At the last count of the last cycle, `cycle` returns to 0.
- Instruction end, no redirect pending: `instr` ← prefetch buffer, `pc_reg` ← `pc_reg`+4 (mod 2^32). Stay in RUN.
- Instruction end, redirect pending: `pc_reg` ← `{branch_target[31:1],1'b0}`, clear pending, go to GAP. The sequentially prefetched word is discarded and `instr` is held.
- `branch` sampled high at any RUN clock sets the pending flag. Multiple pulses within one instruction act as one.
- `next_instr`: the prefetch buffer. At `counter`=31 of cycle 0, bit 24 (the last to arrive) is supplied combinationally from `spi_miso`, so all 31 bits are valid that clock.

## Timing
- Reset values:
  - Control outputs: `spi_cs_n`=1, `spi_clk_en`=0, `spi_mosi`=0, `run`=0.
  - Sequencer: `counter`=0, `cycle`=0, state GAP.
  - Data: `instr`=32'h0000_0013 (NOP), `next_instr`=0, `pc_reg`=RESET_PC, pending=0.
- Reset deassert to first `run`=1: 1 (GAP) + 32 (CMD) + 32 (FILL) = 65 clocks; 73 with fast read.
- Redirect penalty: the same 65/73 clocks after the instruction end.
- Sequential execution: zero fetch stall. The next word completes exactly at `counter`=31 of cycle 0.
- `branch` asserted on the final clock of an instruction still redirects at that instruction end.
- `rst` asserted mid-CMD/FILL/RUN: all state returns to reset values immediately and CS releases asynchronously.
- Outputs other than `pc` and `next_instr[24]` are registered.

## Configuration
- `NANOV_FETCH_FAST_READ_EN` defined:
  - Command is 8'h0B.
  - 8 dummy clocks (`spi_mosi`=0, `spi_clk_en`=1) follow the address.
  - CMD lasts 40 clocks.
- `NANOV_FETCH_FAST_READ_EN` undefined: command 8'h03, no dummy clocks.

## Test plan
- Reset, RESET_PC=0, flash word 0 = 32'h0040_0093 → `spi_mosi` stream = 8'h03, 24'h000000.
  - `run` rises at clock 65 with `instr`=32'h0040_0093.
  - `pc` bits all 0.
- Three sequential ADDIs → no stall; `instr` updates every 32 clocks; PC reaches 0x8, 0xC.
- LOAD at PC 0x4 → `spi_clk_en` low for 64 clocks (cycles 1-2); next `instr` valid at 96 clocks after load start; PC = 0x8.
- JAL at PC 0x10, `branch` pulsed at cycle 0 counter 0, `branch_target`=0x0000_0101 at end → GAP, CMD address 0x000100, `pc_reg`=0x100, prefetched word discarded.
- `rst` asserted during FILL → `spi_cs_n`=1 and `run`=0 same clock; full 65-clock refetch from RESET_PC.
- With `NANOV_FETCH_FAST_READ_EN` → command 8'h0B, 8 dummy clocks, first `run` at clock 73.
